// File: rtl/shift_controller.sv
// shift_controller: MSB-first serial word transmitter/receiver with a programmable step divider
// Ports: clk, rst_n (async active-low clear); start_i, abort_i, din_i[N-1:0] (word to send), sin_i (receive bit);
//        sout_o (transmit bit), shift_en_o (shift strobe), busy_o, done_o (completion pulse), dout_o[N-1:0] (received word)
module shift_controller #(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [N-1:0] din_i,
  input  logic         sin_i,
  output logic         sout_o,
  output logic         shift_en_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] dout_o
);
  localparam int BW = $clog2(N + 1);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(N - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d, dout_q, dout_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0] divcnt_q, divcnt_d;
  logic          step;
  // Outputs decode straight from state so the async clear zeroes them without an edge.
  assign step       = state_q == SHIFT && divcnt_q == DMAX;
  assign shift_en_o = step;
  assign sout_o     = state_q == SHIFT && shreg_q[N-1];
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign dout_o     = dout_q;
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        state_d  = SHIFT;
        shreg_d  = din_i;
        bitcnt_d = '0;
        divcnt_d = '0;
      end
      SHIFT: if (abort_i) state_d = IDLE;
      else begin
        divcnt_d = step ? '0 : divcnt_q + 1'b1;
        if (step) begin
          shreg_d  = {shreg_q[N-2:0], sin_i};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BMAX) begin
            dout_d  = {shreg_q[N-2:0], sin_i};
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      dout_q   <= dout_d;
    end
  end
endmodule

// File: tb/tb_shift_controller.sv
// tb_shift_controller: directed checks of shift_controller with DIV=1 and DIV=3 instances
module tb_shift_controller;
  logic clk, rst_n;
  logic start0, abort0, sin_v, loop0, sin0, sout0, sen0, busy0, done0;
  logic [3:0] din0, dout0;
  logic start1, abort1, sin1, sout1, sen1, busy1, done1;
  logic [3:0] din1, dout1;
  int errors = 0, checks = 0, ndone;
  assign sin0 = loop0 ? sout0 : sin_v;
  shift_controller #(.N(4), .DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0), .din_i(din0), .sin_i(sin0),
    .sout_o(sout0), .shift_en_o(sen0), .busy_o(busy0), .done_o(done0), .dout_o(dout0));
  shift_controller #(.N(4), .DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .din_i(din1), .sin_i(sin1),
    .sout_o(sout1), .shift_en_o(sen1), .busy_o(busy1), .done_o(done1), .dout_o(dout1));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic zero0(input string tag);
    chk({tag, "_sout"}, 32'(sout0), 0);
    chk({tag, "_sen"}, 32'(sen0), 0);
    chk({tag, "_busy"}, 32'(busy0), 0);
    chk({tag, "_done"}, 32'(done0), 0);
  endtask
  initial begin
    logic [3:0] pat;
    logic [12:0] s1;
    rst_n = 1; start0 = 0; abort0 = 0; din0 = 0; sin_v = 0; loop0 = 0;
    start1 = 0; abort1 = 0; din1 = 0; sin1 = 1;
    #1 rst_n = 0;
    #1 zero0("rst");
    chk("rst_dout", 32'(dout0), 0);
    tick; tick;
    rst_n = 1;
    tick;
    zero0("idle");
    // loopback transfer of 1011
    loop0 = 1; din0 = 4'b1011; start0 = 1;
    tick;
    start0 = 0;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk("lb_sout", 32'(sout0), 32'(pat[3-i]));
      chk("lb_sen", 32'(sen0), 1);
      chk("lb_busy", 32'(busy0), 1);
      chk("lb_done", 32'(done0), 0);
      tick;
    end
    chk("lb_done5", 32'(done0), 1);
    chk("lb_dout", 32'(dout0), 4'b1011);
    chk("lb_sout_done", 32'(sout0), 0);
    tick;
    zero0("lb_after");
    // start re-pulsed mid-transfer is ignored
    din0 = 4'b1100; start0 = 1;
    tick;
    start0 = 0;
    tick;
    din0 = 4'b0001; start0 = 1;
    tick;
    start0 = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      ndone += int'(done0);
      tick;
    end
    chk("ign_ndone", 32'(ndone), 1);
    chk("ign_dout", 32'(dout0), 4'b1100);
    chk("ign_busy", 32'(busy0), 0);
    // abort after two shifts
    loop0 = 0; sin_v = 0; din0 = 4'b1111; start0 = 1;
    tick;
    start0 = 0;
    tick; tick;
    abort0 = 1;
    tick;
    abort0 = 0;
    zero0("abort");
    chk("abort_dout", 32'(dout0), 4'b1100);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      ndone += int'(done0);
      tick;
    end
    chk("abort_ndone", 32'(ndone), 0);
    loop0 = 1; din0 = 4'b1010; start0 = 1;
    tick;
    start0 = 0;
    tick; tick; tick;
    tick;
    chk("abort_re_done", 32'(done0), 1);
    chk("abort_re_dout", 32'(dout0), 4'b1010);
    tick;
    // start with abort in idle stays idle
    start0 = 1; abort0 = 1;
    tick;
    start0 = 0; abort0 = 0;
    zero0("sa_idle");
    tick;
    chk("sa_busy2", 32'(busy0), 0);
    // async clear mid-transfer
    din0 = 4'b0110; start0 = 1;
    tick;
    start0 = 0;
    tick; tick;
    chk("clr_busy_pre", 32'(busy0), 1);
    #2 rst_n = 0;
    #1 zero0("clr");
    chk("clr_dout", 32'(dout0), 0);
    tick;
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      ndone += int'(done0);
      tick;
    end
    chk("clr_ndone", 32'(ndone), 0);
    din0 = 4'b1001; start0 = 1;
    tick;
    start0 = 0;
    tick; tick; tick;
    tick;
    chk("clr_re_done", 32'(done0), 1);
    chk("clr_re_dout", 32'(dout0), 4'b1001);
    tick;
    // DIV=3: 0110 shifted with SIN=1, expected SOUT per cycle 1..13
    s1 = 13'b0_000_111_111_000;
    din1 = 4'b0110; start1 = 1;
    tick;
    start1 = 0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("d3_sen_c%0d", c), 32'(sen1), 32'(c % 3 == 0 && c <= 12));
      chk($sformatf("d3_done_c%0d", c), 32'(done1), 32'(c == 13));
      chk($sformatf("d3_sout_c%0d", c), 32'(sout1), 32'(s1[c-1]));
      if (c < 13) tick;
    end
    chk("d3_dout", 32'(dout1), 4'b1111);
    tick;
    chk("d3_busy_end", 32'(busy1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 Parameter N, default 4: word width in bits; N >= 2.
REQ-002 Parameter DIV, default 1: clock cycles per shift step; DIV >= 1.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 CLR  input  1  asynchronous active-low reset.
REQ-005 START  input  1  request to begin a word transfer; sampled only in IDLE.
REQ-006 ABORT  input  1  synchronous abort; returns to IDLE without DONE.
REQ-007 DIN  input  N  parallel word to transmit; captured on the accepted START edge.
REQ-008 SIN  input  1  serial receive bit; sampled on each shift edge.
REQ-009 SOUT  output  1  serial transmit bit, MSB first.
REQ-010 SHIFT_EN  output  1  one-cycle strobe marking each shift step.
REQ-011 BUSY  output  1  high in SHIFT and DONE states.
REQ-012 DONE  output  1  one-cycle pulse when a word completes.
REQ-013 DOUT  output  N  received word; registered; held until the next completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE, and no others.
REQ-015 IDLE -> SHIFT when START=1 and ABORT=0: load shreg<=DIN, bitcnt<=0, divcnt<=0.
REQ-016 START in SHIFT or DONE SHALL be ignored; there is no queuing.
REQ-017 In SHIFT, divcnt counts 0..DIV-1 and wraps; SHIFT_EN=1 exactly when divcnt==DIV-1.
REQ-018 On each SHIFT_EN edge: shreg <= {shreg[N-2:0],SIN}; bitcnt increments.
REQ-019 On the SHIFT_EN edge with bitcnt==N-1: DOUT <= {shreg[N-2:0],SIN}; state -> DONE.
REQ-020 SOUT SHALL be shreg[N-1] in SHIFT; 0 in IDLE and DONE.
REQ-021 DONE SHALL be 1 for exactly one cycle; the next state is unconditionally IDLE.
REQ-022 Latency: START accepted at edge k -> SHIFT for N*DIV cycles -> DONE high in cycle k+N*DIV+1.
REQ-023 SHIFT_EN SHALL fire exactly N times per word; it is 0 outside SHIFT.
REQ-024 ABORT=1 in SHIFT or DONE -> IDLE at the next edge; DONE stays 0; DOUT unchanged.
REQ-025 ABORT has priority over START and over completion on the same edge.
REQ-026 With DIV=1, SHIFT_EN SHALL be high on every SHIFT cycle.
REQ-027 The first received bit SHALL land in DOUT[N-1]; the last in DOUT[0].
REQ-028 Counter widths SHALL hold N and DIV-1 without overflow; wrap occurs only as stated.

Reset
REQ-029 CLR=0 SHALL immediately force: state=IDLE, shreg=0, bitcnt=0, divcnt=0, DOUT=0, SOUT=0, SHIFT_EN=0, BUSY=0, DONE=0.
REQ-030 CLR asserted mid-transfer SHALL discard the word; no DONE pulse follows.
REQ-031 After CLR releases, the first START SHALL be accepted normally.

Verification
REQ-032 N=4, DIV=1, DIN=4'b1011, SIN looped to SOUT, START one cycle -> SOUT sequence 1,0,1,1; DONE in cycle 5 after START; DOUT=4'b1011.
REQ-033 N=4, DIV=3, DIN=4'b0110, SIN=1 constant -> SHIFT_EN pulses 3 cycles apart, 4 pulses total; DONE at cycle 13; DOUT=4'b1111.
REQ-034 START re-pulsed during SHIFT with DIN=4'b0001 -> ignored; the original word completes; exactly one DONE.
REQ-035 ABORT after 2 shifts -> IDLE next cycle; BUSY=0; no DONE; DOUT keeps its prior value; a new START then completes normally.
REQ-036 START and ABORT high together in IDLE -> remains IDLE; BUSY=0.
REQ-037 CLR pulsed low after 2 shifts -> all outputs 0 immediately, without waiting for a clock edge; no DONE; a subsequent START transfers correctly.
